// File: rtl/any1_decode_queue.sv
// rtl/any1_decode_queue.sv - Any1 decode stage feeding a QDEPTH-entry FIFO of decoded entries
// Optional immediate-prefix support is enabled by defining ANY1_IMM_PREFIX_EN.
module any1_decode_queue #(
  parameter int QDEPTH = 4,
  parameter int AWID   = 32,
  parameter int RIDW   = 6
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [RIDW-1:0]          in_rid_i,
  input  logic [AWID-1:0]          in_ip_i,
  input  logic [AWID-1:0]          in_pip_i,
  input  logic [63:0]              in_ir_i,
  input  logic                     in_predict_taken_i,
  input  logic                     in_stream_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [RIDW+2*AWID+157:0] out_dec_o,
  output logic [$clog2(QDEPTH):0]  count_o
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  localparam logic [6:0] OP_R1 = 7'h01, OP_R2 = 7'h02, OP_R3 = 7'h03;
  localparam logic [6:0] OP_ADDI = 7'h04, OP_SUBFI = 7'h05, OP_MULI = 7'h06, OP_DIVI = 7'h07;
  localparam logic [6:0] OP_SEQI = 7'h08, OP_SNEI = 7'h09, OP_SLTI = 7'h0A, OP_SGTI = 7'h0B;
  localparam logic [6:0] OP_MULUI = 7'h0C, OP_MULSUI = 7'h0D, OP_DIVUI = 7'h0E, OP_DIVSUI = 7'h0F;
  localparam logic [6:0] OP_ORI = 7'h10, OP_XORI = 7'h11, OP_SLTUI = 7'h12, OP_SGTUI = 7'h13;
  localparam logic [6:0] OP_ANDI = 7'h14, OP_BYTNDX = 7'h15, OP_U21NDX = 7'h16, OP_PERM = 7'h17;
  localparam logic [6:0] OP_EXT = 7'h18, OP_EXTU = 7'h19, OP_CHKI = 7'h1A;
  localparam logic [6:0] OP_JAL = 7'h20, OP_BAL = 7'h21, OP_JALR = 7'h22;
  localparam logic [6:0] OP_BCC0 = 7'h28, OP_BCC7 = 7'h2F, OP_LEA = 7'h30, OP_LD7 = 7'h37;
  localparam logic [6:0] OP_ST0 = 7'h38, OP_ST7 = 7'h3F, OP_SYS = 7'h40, OP_NOP = 7'h7F;
  localparam logic [5:0] F_ABS = 6'h0C, F_NOT = 6'h08, F_V2BITS = 6'h18, F_CHK = 6'h30;

  typedef struct packed {
    logic [RIDW-1:0] rid;
    logic [AWID-1:0] ip;
    logic [AWID-1:0] pip;
    logic [63:0]     ir;
    logic [5:0]      ra;
    logic [5:0]      rb;
    logic [5:0]      rt;
    logic [5:0]      rc;
    logic            rfwr;
    logic [63:0]     imm;
    logic            ui;
    logic            is_vec;
    logic            stream;
    logic            stream_inc;
    logic            predict_taken;
  } dec_t;

  logic [6:0]    op;
  logic [5:0]    func;
  logic          is_pfx, accept, push, pop;
  logic          in_ready_q, in_ready_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  dec_t          dec;
  dec_t          mem_q [QDEPTH];

  assign op     = in_ir_i[6:0];
  assign func   = in_ir_i[31:26];
  assign accept = in_valid_i & in_ready_q & ~flush_i;
  assign push   = accept & ~is_pfx;
  assign pop    = (count_q != '0) & out_ready_i & ~flush_i;

`ifdef ANY1_IMM_PREFIX_EN
  localparam logic [6:0] OP_IMMPFX = 7'h50;
  typedef enum logic {PFX_IDLE, PFX_HELD} pfx_e;
  pfx_e        pfx_q, pfx_d;
  logic [23:0] pfx_data_q, pfx_data_d;
  logic        has_imm12;

  assign is_pfx    = (op == OP_IMMPFX);
  assign has_imm12 = op inside {[OP_ADDI:OP_ANDI], OP_CHKI};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pfx_q      <= PFX_IDLE;
      pfx_data_q <= '0;
    end else begin
      pfx_q      <= pfx_d;
      pfx_data_q <= pfx_data_d;
    end
  end

  // Any accepted non-prefix instruction consumes or discards the held payload.
  always_comb begin
    pfx_d      = pfx_q;
    pfx_data_d = pfx_data_q;
    if (flush_i) begin
      pfx_d = PFX_IDLE;
    end else if (accept) begin
      if (is_pfx) begin
        pfx_d      = PFX_HELD;
        pfx_data_d = in_ir_i[31:8];
      end else begin
        pfx_d = PFX_IDLE;
      end
    end
  end
`else
  assign is_pfx = 1'b0;
`endif

  always_comb begin
    dec               = '0;
    dec.rid           = in_rid_i;
    dec.ip            = in_ip_i;
    dec.pip           = in_pip_i;
    dec.ir            = in_ir_i;
    dec.ra            = in_ir_i[19:14];
    dec.rb            = in_ir_i[25:20];
    dec.ui            = 1'b1;
    dec.is_vec        = in_ir_i[7];
    dec.stream        = in_stream_i;
    dec.predict_taken = in_predict_taken_i;
    case (op) inside
      OP_R1:
        if (func inside {F_ABS, F_NOT, F_V2BITS}) begin
          dec.rt = in_ir_i[13:8]; dec.rfwr = 1'b1; dec.ui = 1'b0;
        end
      OP_R2: begin
        dec.rt = in_ir_i[13:8]; dec.rfwr = 1'b1; dec.ui = 1'b0;
      end
      OP_R3:
        if (func == F_CHK) begin
          dec.rc = in_ir_i[13:8]; dec.ui = 1'b0;
        end else begin
          dec.rt = in_ir_i[13:8]; dec.rfwr = 1'b1; dec.ui = 1'b0;
        end
      [OP_ADDI:OP_SGTI]: begin
        dec.imm = {{52{in_ir_i[31]}}, in_ir_i[31:20]};
        dec.rt = in_ir_i[13:8]; dec.rfwr = 1'b1; dec.ui = 1'b0;
      end
      [OP_MULUI:OP_SGTUI]: begin
        dec.imm = {52'h0, in_ir_i[31:20]};
        dec.rt = in_ir_i[13:8]; dec.rfwr = 1'b1; dec.ui = 1'b0;
      end
      OP_ANDI: begin
        dec.imm = {{52{1'b1}}, in_ir_i[31:20]};
        dec.rt = in_ir_i[13:8]; dec.rfwr = 1'b1; dec.ui = 1'b0;
      end
      OP_BYTNDX, OP_U21NDX, OP_PERM: begin
        dec.imm = {56'h0, in_ir_i[27:20]};
        dec.rt = in_ir_i[13:8]; dec.rfwr = 1'b1; dec.ui = 1'b0;
      end
      OP_EXT, OP_EXTU: begin
        dec.rt = in_ir_i[13:8]; dec.rfwr = 1'b1; dec.ui = 1'b0;
      end
      OP_CHKI: begin
        dec.imm = {{52{in_ir_i[31]}}, in_ir_i[31:20]}; dec.ui = 1'b0;
      end
      OP_JAL, OP_BAL: begin
        dec.rt = {4'h0, in_ir_i[9:8]}; dec.rfwr = 1'b1; dec.ui = 1'b0;
        dec.imm = {{41{in_ir_i[31]}}, in_ir_i[31:10], 1'b0};
        dec.stream_inc = 1'b1;
      end
      OP_JALR: begin
        dec.rt = {4'h0, in_ir_i[9:8]}; dec.rfwr = 1'b1; dec.ui = 1'b0;
        dec.imm = {{47{in_ir_i[31]}}, in_ir_i[31:20], in_ir_i[13:10], 1'b0};
      end
      [OP_BCC0:OP_BCC7]: begin
        dec.rt = in_ir_i[13:8]; dec.rfwr = 1'b1; dec.ui = 1'b0;
        dec.imm = {{49{in_ir_i[31]}}, in_ir_i[31:26], in_ir_i[13:8], 3'b000};
      end
      [OP_LEA:OP_LD7]: begin
        dec.rt = in_ir_i[13:8]; dec.rfwr = 1'b1; dec.ui = 1'b0;
        dec.imm = {{44{in_ir_i[59]}}, in_ir_i[59:48], in_ir_i[39:32]};
      end
      [OP_ST0:OP_ST7]: begin
        dec.rc = in_ir_i[13:8]; dec.ui = 1'b0;
        dec.imm = {{44{in_ir_i[59]}}, in_ir_i[59:48], in_ir_i[39:32]};
      end
      OP_SYS:
        case (in_ir_i[47:45])
          3'd0, 3'd1: dec.ui = 1'b0;
          3'd2: begin dec.rt = in_ir_i[13:8]; dec.rfwr = 1'b1; dec.ui = 1'b0; end
          default: ;
        endcase
      OP_NOP: dec.ui = 1'b0;
      default: ;
    endcase
`ifdef ANY1_IMM_PREFIX_EN
    if (pfx_q == PFX_HELD && has_imm12)
      dec.imm = {{28{pfx_data_q[23]}}, pfx_data_q, in_ir_i[31:20]};
`endif
  end

  // QDEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    wr_d    = wr_q + PW'(push);
    rd_d    = rd_q + PW'(pop);
    count_d = count_q + CW'(push) - CW'(pop);
    if (flush_i) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end
    in_ready_d = (count_d < CW'(QDEPTH));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b1;
    end else begin
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q] <= dec;
  end

  assign out_valid_o = (count_q != '0);
  assign out_dec_o   = out_valid_o ? mem_q[rd_q] : '0;
  assign in_ready_o  = in_ready_q;
  assign count_o     = count_q;
endmodule
